// File: rtl/disk_uart_pkg.sv
// disk_uart_pkg: shared receive-state encoding and sizing constants for the disk UART ingress.
package disk_uart_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } rx_state_t;
  localparam int CLKS_PER_BIT_DEF = 434;
  localparam int LANES = 4;
endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: synchronised UART byte receiver with stop/parity error pulses.
// Even parity (8E1) is selected by defining DISK_UART_RX_PARITY_EN.
module uart_rx_byte
  import disk_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err,
`ifdef DISK_UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output rx_state_t  state
);
  localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL = 16'(CLKS_PER_BIT - 1);
`ifdef DISK_UART_RX_PARITY_EN
  localparam rx_state_t AFTER_DATA = PARITY;
`else
  localparam rx_state_t AFTER_DATA = STOP;
`endif
  rx_state_t state_n;
  logic s1, s2, s2_d;
  logic [15:0] cnt, cnt_n;
  logic [2:0] bit_idx, bit_n;
  logic [7:0] sh, sh_n;
  logic hold, hold_n;
  logic bad, bad_n;
  logic valid_n, ferr_n;
  logic tick;
`ifdef DISK_UART_RX_PARITY_EN
  logic perr_n;
`endif
  assign tick = cnt == FULL;
  assign byte_data = sh;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s2_d <= 1'b1;
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      sh <= '0;
      hold <= 1'b0;
      bad <= 1'b0;
      byte_valid <= 1'b0;
      frame_err <= 1'b0;
`ifdef DISK_UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      s1 <= rxd;
      s2 <= s1;
      s2_d <= s2;
      state <= state_n;
      cnt <= cnt_n;
      bit_idx <= bit_n;
      sh <= sh_n;
      hold <= hold_n;
      bad <= bad_n;
      byte_valid <= valid_n;
      frame_err <= ferr_n;
`ifdef DISK_UART_RX_PARITY_EN
      parity_err <= perr_n;
`endif
    end
  end
  // hold marks a bad stop bit: stay in STOP until the line returns high
  always_comb begin
    state_n = state;
    cnt_n = cnt + 16'd1;
    bit_n = bit_idx;
    sh_n = sh;
    hold_n = hold;
    bad_n = bad;
    valid_n = 1'b0;
    ferr_n = 1'b0;
`ifdef DISK_UART_RX_PARITY_EN
    perr_n = 1'b0;
`endif
    case (state)
      IDLE: begin
        cnt_n = '0;
        bad_n = 1'b0;
        state_n = (s2_d & ~s2) ? START : IDLE;
      end
      START: if (cnt == HALF) begin
        cnt_n = '0;
        bit_n = '0;
        state_n = s2 ? IDLE : DATA;
      end
      DATA: if (tick) begin
        cnt_n = '0;
        sh_n = {s2, sh[7:1]};
        bit_n = bit_idx + 3'd1;
        state_n = (bit_idx == 3'd7) ? AFTER_DATA : DATA;
      end
`ifdef DISK_UART_RX_PARITY_EN
      PARITY: if (tick) begin
        cnt_n = '0;
        bad_n = s2 ^ (^sh);
        perr_n = s2 ^ (^sh);
        state_n = STOP;
      end
`endif
      STOP: if (hold) begin
        cnt_n = '0;
        hold_n = ~s2;
        state_n = s2 ? IDLE : STOP;
      end else if (tick) begin
        cnt_n = '0;
        valid_n = s2 & ~bad;
        ferr_n = ~s2;
        hold_n = ~s2;
        state_n = s2 ? IDLE : STOP;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: rtl/disk_uart_rx_assembler.sv
// disk_uart_rx_assembler: packs UART bytes into little-endian 32-bit words written sequentially into the disk buffer.
// Defining DISK_UART_RX_PARITY_EN selects 8E1 framing and adds parity_err.
module disk_uart_rx_assembler
  import disk_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RxD,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              frame_done,
  output logic              frame_err,
`ifdef DISK_UART_RX_PARITY_EN
  output logic              parity_err,
`endif
  output logic [2:0]        Rstate
);
  rx_state_t st;
  logic byte_valid;
  logic [7:0] byte_data;
  logic [1:0] lane;
  logic [23:0] word;
  logic last;
  assign Rstate = st;
  assign last = byte_valid && lane == 2'(LANES - 1);
  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk(clk),
    .rst(rst),
    .rxd(RxD),
    .byte_valid(byte_valid),
    .byte_data(byte_data),
    .frame_err(frame_err),
`ifdef DISK_UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .state(st)
  );
  // lanes 0..2 shift into word so lane k ends up at bits [8k+7:8k]
  always_ff @(posedge clk) begin
    if (rst) begin
      lane <= '0;
      word <= '0;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      frame_done <= 1'b0;
    end else begin
      wr_en <= last;
      frame_done <= last && &wr_addr;
      if (wr_en) wr_addr <= wr_addr + 1'b1;
      if (byte_valid) lane <= lane + 2'd1;
      if (byte_valid && !last) word <= {byte_data, word[23:8]};
      if (last) wr_data <= {byte_data, word};
    end
  end
endmodule
